// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start pattern, CNT_W-bit length, then L payload bits, MSB first.
// Latency: first pattern bit on ser_out the cycle after start; one bit per cycle, no gaps.
// Backpressure: none on the line; a late payload byte sends zeros and sets sticky underrun.
module serial_frame_tx #(
    parameter int               PAT_W = 4,
    parameter logic [PAT_W-1:0] PAT   = 4'b1101,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] length,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int HDR_W = PAT_W + CNT_W;
    localparam int HC_W  = $clog2(HDR_W);

    typedef enum logic [2:0] {ST_IDLE, ST_PAT, ST_LEN, ST_DATA, ST_DONE} state_t;

    state_t           state;
    logic [HDR_W-1:0] hdrSr;
    logic [HC_W-1:0]  hdrCnt;
    logic [CNT_W-1:0] lenReg;
    logic [CNT_W-1:0] payCnt;
    logic [7:0]       holdReg;
    logic             holdFull;
    logic [7:0]       dataSr;
    logic [2:0]       bitPos;
    logic [CNT_W:0]   fetched;
    logic [CNT_W:0]   bytesNeeded;
    logic [7:0]       nextByte;
    logic             take;

    assign bytesNeeded = ({1'b0, lenReg} + (CNT_W+1)'(7)) >> 3;
    assign data_ready  = busy & ~holdFull & (fetched < bytesNeeded);
    assign take        = data_valid & data_ready;
    // An empty holding register at a byte boundary substitutes zeros.
    assign nextByte    = holdFull ? holdReg : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            hdrSr      <= '0;
            hdrCnt     <= '0;
            lenReg     <= '0;
            payCnt     <= '0;
            holdReg    <= '0;
            holdFull   <= 1'b0;
            dataSr     <= '0;
            bitPos     <= '0;
            fetched    <= '0;
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (take) begin
                holdReg  <= data_in;
                holdFull <= 1'b1;
                fetched  <= fetched + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    ser_out <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        state    <= ST_PAT;
                        lenReg   <= length;
                        underrun <= 1'b0;
                        busy     <= 1'b1;
                        fetched  <= '0;
                        holdFull <= 1'b0;
                        ser_out  <= PAT[PAT_W-1];
                        hdrSr    <= {PAT[PAT_W-2:0], length, 1'b0};
                        hdrCnt   <= HC_W'(HDR_W - 1);
                    end
                end
                ST_PAT, ST_LEN: begin
                    if (hdrCnt != '0) begin
                        ser_out <= hdrSr[HDR_W-1];
                        hdrSr   <= hdrSr << 1;
                        hdrCnt  <= hdrCnt - 1'b1;
                        if (hdrCnt == HC_W'(CNT_W)) state <= ST_LEN;
                    end else if (lenReg == '0) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ser_out <= 1'b0;
                    end else begin
                        state      <= ST_DATA;
                        payCnt     <= lenReg - 1'b1;
                        bitPos     <= 3'd0;
                        ser_active <= 1'b1;
                        ser_out    <= nextByte[7];
                        dataSr     <= {nextByte[6:0], 1'b0};
                        if (holdFull) holdFull <= 1'b0;
                        else          underrun <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (payCnt == '0) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        ser_active <= 1'b0;
                        ser_out    <= 1'b0;
                    end else begin
                        payCnt <= payCnt - 1'b1;
                        bitPos <= bitPos + 3'd1;
                        if (bitPos == 3'd7) begin
                            ser_out <= nextByte[7];
                            dataSr  <= {nextByte[6:0], 1'b0};
                            if (holdFull) holdFull <= 1'b0;
                            else          underrun <= 1'b1;
                        end else begin
                            ser_out <= dataSr[7];
                            dataSr  <= dataSr << 1;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    ser_out <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: per-cycle expected line state is queued when a frame is launched
// and popped/compared every cycle while the frame runs.
module tb_serial_frame_tx;

    localparam int         PAT_W = 4;
    localparam logic [3:0] PAT   = 4'b1101;
    localparam int         CNT_W = 8;
    localparam int         HDR_W = PAT_W + CNT_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] length;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       ser_out;
    logic       ser_active;
    logic       busy;
    logic       done;
    logic       underrun;

    serial_frame_tx #(.PAT_W(PAT_W), .PAT(PAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .length     (length),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int         nCompared = 0;
    int         nMismatch = 0;
    logic [7:0] txBytes[$];
    logic [4:0] expQ[$];
    int         handshakes;
    int         readyCycles;
    logic       expUr = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected vector per cycle: {ser_out, ser_active, busy, done, underrun}.
    task automatic runFrame(input int len, input int restartAt, input int abortAt);
        int               need;
        int               supplied;
        int               total;
        int               urFrom;
        int               p;
        logic [7:0]       bytes[$];
        logic [7:0]       curByte;
        logic [HDR_W-1:0] hdr;
        logic             bitVal;
        logic [4:0]       exp;
        bit               aborted;

        need     = (len + 7) / 8;
        bytes    = txBytes;
        supplied = bytes.size();
        total    = HDR_W + len;
        hdr      = {PAT, 8'(len)};
        urFrom   = (supplied < need) ? HDR_W + 1 + 8 * supplied : 1 << 30;
        aborted  = 1'b0;

        expQ.delete();
        expQ.push_back({4'b0000, expUr});
        for (int c = 1; c <= total; c++) begin
            if (c <= HDR_W) begin
                bitVal = hdr[HDR_W - c];
            end else begin
                p       = c - HDR_W - 1;
                curByte = (p / 8 < supplied) ? bytes[p / 8] : 8'h00;
                bitVal  = curByte[7 - (p % 8)];
            end
            expQ.push_back({bitVal, c > HDR_W, 1'b1, 1'b0, c >= urFrom});
        end
        expQ.push_back({4'b0001, urFrom <= total});

        handshakes  = 0;
        readyCycles = 0;
        for (int c = 0; c <= total + 1; c++) begin
            @(negedge clk);
            exp = expQ.pop_front();
            checkEq($sformatf("L=%0d cycle %0d line/active/busy/done/underrun", len, c),
                    32'({ser_out, ser_active, busy, done, underrun}), 32'(exp));
            if (data_ready) readyCycles++;
            if (c == abortAt) begin
                rst = 1'b0;
                #1;
                checkEq($sformatf("abort L=%0d cycle %0d outputs", len, c),
                        32'({ser_out, ser_active, busy, data_ready, done, underrun}), 32'd0);
                aborted = 1'b1;
                break;
            end
            start  = (c == 0) || (c == restartAt);
            length = (c == 0) ? 8'(len) : 8'd3;
            data_valid = (txBytes.size() > 0);
            data_in    = (txBytes.size() > 0) ? txBytes[0] : 8'h00;
            if (data_valid && data_ready) begin
                handshakes++;
                void'(txBytes.pop_front());
            end
        end
        start      = 1'b0;
        data_valid = 1'b0;
        txBytes.delete();
        if (aborted) begin
            expUr = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checkEq($sformatf("after abort idle %0d", k),
                        32'({ser_out, ser_active, busy, done}), 32'd0);
                rst = 1'b1;
            end
        end else begin
            expUr = (supplied < need);
            checkEq($sformatf("L=%0d handshakes", len), 32'(handshakes),
                    32'((supplied < need) ? supplied : need));
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        length     = 8'd0;
        data_in    = 8'd0;
        data_valid = 1'b0;
        #12;
        checkEq("reset outputs", 32'({ser_out, ser_active, busy, done, underrun, data_ready}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        txBytes = '{8'hA5};
        runFrame(8, -1, -1);

        runFrame(0, -1, -1);
        checkEq("L=0 ready cycles", 32'(readyCycles), 32'd0);

        txBytes = '{8'h3C, 8'hF0};
        runFrame(12, -1, -1);

        txBytes = '{8'hFF};
        runFrame(16, -1, -1);

        txBytes = '{8'hA5};
        runFrame(8, 5, -1);
        txBytes = '{8'h5A};
        runFrame(8, -1, -1);

        txBytes = '{8'h81, 8'h7E, 8'hE7};
        runFrame(20, -1, -1);

        txBytes = '{8'hA5};
        runFrame(8, -1, 15);
        txBytes = '{8'hC3};
        runFrame(8, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Transmit side of the team's serial framing protocol: start pattern, then length, then payload.
- On a start request it drives one serial line with the start pattern (MSB first), then the CNT_W-bit payload length L (MSB first), then L payload bits.
- Payload bits are taken MSB first from bytes fetched over a valid/ready handshake.
- ser_active marks the payload window, mirroring the receiver's output-valid window. This makes the block a drop-in stimulus source and link partner for the serial receiver chain.

Parameters:
PAT_W, 4, start-pattern width in bits
PAT, 4'b1101, start pattern, sent MSB first; MSB must be 1 (idle line is 0)
CNT_W, 8, length-field width; payload length L in bits, 0..2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
start  input  1  frame request, sampled only in IDLE
length  input  CNT_W  payload length L in bits, latched with start
data_in  input  8  payload byte, bit 7 sent first
data_valid  input  1  data_in valid
data_ready  output  1  transmitter can accept a byte this cycle
ser_out  output  1  serial line, registered
ser_active  output  1  high exactly during payload bits
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse after last frame bit
underrun  output  1  sticky error: a payload byte was needed but not buffered

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; holding register empty; fetch/bit counters 0.
- States: IDLE -> PAT -> LEN -> DATA -> DONE -> IDLE. DATA is skipped when L=0 (LEN -> DONE).
- Cycle 0: IDLE with start=1. Latch L; clear underrun; go to PAT.
- Cycles 1..PAT_W: ser_out = PAT bits, MSB first.
- Next CNT_W cycles: ser_out = L bits, MSB first.
- Next L cycles: DATA. ser_out = payload bit, ser_active=1.
- Following cycle: DONE. done=1, ser_out=0, busy=0. Then IDLE.
- Total frame = PAT_W + CNT_W + L bit cycles, with no gaps.
- Byte buffer: one 8-bit holding register plus an 8-bit shift register.
  - Bytes needed B = ceil(L/8).
  - data_ready = busy & holding empty & fetched < B. It is combinational from registered state, never depends on data_valid, and is asserted from cycle 1 (PAT) onward.
  - A transfer occurs on a rising edge with data_valid & data_ready; holding becomes full and fetched increments.
- At each payload byte boundary (first DATA cycle and every 8th bit after):
  - Holding full: the shift register loads it; holding empties in the same edge, so a new byte may be accepted next cycle.
  - Holding empty: the shift register loads 8'h00, underrun=1 (sticky until next accepted start). The frame continues; timing is never stretched.
- Last partial byte: only the top (L mod 8) bits are sent; the rest are discarded.
- start while busy: ignored; length is not relatched.
- start in the DONE cycle: ignored.
- start in IDLE the cycle after DONE: accepted (back-to-back frames separated by one idle-0 cycle).
- data_valid with data_ready=0: no transfer; the byte is not consumed.
- Idle line: ser_out=0, ser_active=0.
- rst low mid-frame: immediate abort. Outputs 0, buffer flushed; no done pulse.

Test Plan:
- PAT=1101, CNT_W=8, start with L=8, byte 0xA5 offered in cycle 1.
  - ser_out cycles 1-20 = 1101 00001000 10100101.
  - ser_active high cycles 13-20; done=1 at cycle 21; underrun=0.
- L=0.
  - ser_out = 1101 00000000 (cycles 1-12); done at cycle 13.
  - data_ready never asserted; ser_active never high.
- L=12, bytes 0x3C then 0xF0 (second presented with data_valid held until data_ready).
  - Payload bits = 00111100 1111; done at cycle 25; exactly 2 handshakes.
- L=16, only 0xFF supplied.
  - Payload = 11111111 00000000; underrun rises in first cycle of bit 9 (cycle 21) and stays high through done.
  - underrun clears on next accepted start.
- L=8 frame, start pulsed again at cycle 5 with length=3.
  - Ignored: frame unchanged, done at cycle 21.
  - New start at cycle 22 is accepted.
- rst low at cycle 15 of an L=8 frame.
  - Same cycle: ser_out=0, busy=0, ser_active=0, data_ready=0.
  - No done pulse; the next start produces a full clean frame.
